// File: rtl/xadc_drp_bridge_pkg.sv
// Shared constants for the XADC DRP bridge: lbus window, DRP register map,
// FSM state encoding and the pattern returned on a DRP timeout.
package xadc_drp_bridge_pkg;

  localparam logic [11:0] LBUS_WIN_BASE = 12'h800;
  localparam logic [11:0] LBUS_WIN_MASK = 12'hF80;

  localparam logic [6:0] DRP_ADDR_TEMP   = 7'h00;
  localparam logic [6:0] DRP_ADDR_VCCINT = 7'h01;
  localparam logic [6:0] DRP_ADDR_VCCAUX = 7'h02;

  localparam logic [15:0] TIMEOUT_PATTERN = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RDY = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_t;

  function automatic logic in_window(input logic [11:0] addr);
    return (addr & LBUS_WIN_MASK) == LBUS_WIN_BASE;
  endfunction

endpackage

// File: rtl/xadc_drp_bridge_if.sv
// Local-bus cycle from ebi_interface: master drives address/data/strobes,
// slave (the bridge) returns read data and the wait handshake.
interface xadc_drp_bridge_if #(
  parameter int P_ADDR_WIDTH = 12,
  parameter int P_DATA_WIDTH = 16
);
  logic [P_ADDR_WIDTH-1:0] lbus_addr;
  logic [P_DATA_WIDTH-1:0] lbus_wdata;
  logic                    lbus_oe_n;
  logic                    lbus_we_n;
  logic [P_DATA_WIDTH-1:0] lbus_rdata;
  logic                    lbus_wait_n;

  modport master (
    output lbus_addr, lbus_wdata, lbus_oe_n, lbus_we_n,
    input  lbus_rdata, lbus_wait_n
  );

  modport slave (
    input  lbus_addr, lbus_wdata, lbus_oe_n, lbus_we_n,
    output lbus_rdata, lbus_wait_n
  );
endinterface

// File: rtl/xadc_drp_bridge_lbus_strobe_det.sv
// Strobe history for the lbus: start pulses in the first cycle either strobe
// is low after a cycle with both high; strb_idle is the current idle level.
module xadc_drp_bridge_lbus_strobe_det (
  input  logic clk_cfg,
  input  logic rst_cfg,
  input  logic lbus_oe_n,
  input  logic lbus_we_n,
  output logic start,
  output logic strb_idle
);

  logic idle_hist_reg;

  assign strb_idle = lbus_oe_n & lbus_we_n;
  assign start     = ~strb_idle & idle_hist_reg;

  always_ff @(posedge clk_cfg or posedge rst_cfg) begin
    if (rst_cfg) begin
      idle_hist_reg <= 1'b1;
    end else begin
      idle_hist_reg <= strb_idle;
    end
  end

endmodule

// File: rtl/xadc_drp_bridge.sv
// Turns lbus cycles in the 0x800..0x87F window into single XADC DRP accesses,
// holding lbus_wait_n low until the DRP completes. DRP_TIMEOUT_EN adds an abort.
module xadc_drp_bridge
  import xadc_drp_bridge_pkg::*;
#(
  parameter int P_BUS_ADDR_WIDTH = 12,
  parameter int P_BUS_DATA_WIDTH = 16,
  parameter int P_TIMEOUT        = 256
) (
  input  logic                        clk_cfg,
  input  logic                        rst_cfg,
  xadc_drp_bridge_if.slave            lbus,
  output logic [6:0]                  drp_daddr,
  output logic                        drp_den,
  output logic                        drp_dwe,
  output logic [P_BUS_DATA_WIDTH-1:0] drp_di,
  input  logic [P_BUS_DATA_WIDTH-1:0] drp_do,
  input  logic                        drp_drdy,
  output logic                        drp_timeout
);

  state_t                      state_reg;
  kind_t                       kind_reg;
  logic                        wait_n_reg;
  logic [P_BUS_DATA_WIDTH-1:0] rdata_reg;
  logic                        den_reg;
  logic                        dwe_reg;
  logic [6:0]                  daddr_reg;
  logic [P_BUS_DATA_WIDTH-1:0] di_reg;
  logic [P_BUS_ADDR_WIDTH-1:0] addr_in;
  logic                        start;
  logic                        strb_idle;

  assign addr_in          = lbus.lbus_addr;
  assign lbus.lbus_rdata  = rdata_reg;
  assign lbus.lbus_wait_n = wait_n_reg;
  assign drp_daddr        = daddr_reg;
  assign drp_den          = den_reg;
  assign drp_dwe          = dwe_reg;
  assign drp_di           = di_reg;

  xadc_drp_bridge_lbus_strobe_det u_strobe_det (
    .clk_cfg   (clk_cfg),
    .rst_cfg   (rst_cfg),
    .lbus_oe_n (lbus.lbus_oe_n),
    .lbus_we_n (lbus.lbus_we_n),
    .start     (start),
    .strb_idle (strb_idle)
  );

`ifdef DRP_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(P_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(P_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             timeout_reg;

  assign drp_timeout = timeout_reg;
`else
  // Constant 0: P_TIMEOUT has no effect in this build.
  assign drp_timeout = (P_TIMEOUT < 0);
`endif

  always_ff @(posedge clk_cfg or posedge rst_cfg) begin
    if (rst_cfg) begin
      state_reg   <= ST_IDLE;
      kind_reg    <= KIND_READ;
      wait_n_reg  <= 1'b1;
      rdata_reg   <= '0;
      den_reg     <= 1'b0;
      dwe_reg     <= 1'b0;
      daddr_reg   <= DRP_ADDR_TEMP;
      di_reg      <= '0;
`ifdef DRP_TIMEOUT_EN
      tmo_cnt_reg <= '0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      den_reg     <= 1'b0;
      dwe_reg     <= 1'b0;
`ifdef DRP_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            wait_n_reg <= 1'b0;
            // A write strobe overrides a simultaneous read strobe.
            kind_reg   <= lbus.lbus_we_n ? KIND_READ : KIND_WRITE;
            if (in_window(addr_in[11:0])) begin
              den_reg   <= 1'b1;
              dwe_reg   <= ~lbus.lbus_we_n;
              daddr_reg <= addr_in[6:0];
              di_reg    <= lbus.lbus_wdata;
              state_reg <= ST_ISSUE;
            end else begin
              rdata_reg <= '0;
              state_reg <= ST_HOLD;
            end
          end
        end
        ST_ISSUE: begin
`ifdef DRP_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
          state_reg <= ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          // Completion is awaited even if the strobes were already released.
          if (drp_drdy) begin
            if (kind_reg == KIND_READ) begin
              rdata_reg <= drp_do;
            end
            wait_n_reg <= 1'b1;
            state_reg  <= ST_HOLD;
          end
`ifdef DRP_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            rdata_reg   <= P_BUS_DATA_WIDTH'(TIMEOUT_PATTERN);
            wait_n_reg  <= 1'b1;
            timeout_reg <= 1'b1;
            state_reg   <= ST_HOLD;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          wait_n_reg <= 1'b1;
          if (strb_idle) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_bridge.sv
// Scoreboard bench for xadc_drp_bridge: stimulus pushes expected lbus and DRP
// responses; independent monitors pop and compare as the DUT presents them.
module tb_xadc_drp_bridge;

  localparam int TB_TIMEOUT = 64;
  localparam int WAIT_BOUND = 400;

  logic clk_cfg = 1'b0;
  logic rst_cfg = 1'b1;
  always #5 clk_cfg = ~clk_cfg;

  xadc_drp_bridge_if lbus ();

  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        drp_timeout;

  xadc_drp_bridge #(
    .P_BUS_ADDR_WIDTH (12),
    .P_BUS_DATA_WIDTH (16),
    .P_TIMEOUT        (TB_TIMEOUT)
  ) dut (
    .clk_cfg     (clk_cfg),
    .rst_cfg     (rst_cfg),
    .lbus        (lbus),
    .drp_daddr   (drp_daddr),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_di      (drp_di),
    .drp_do      (drp_do),
    .drp_drdy    (drp_drdy),
    .drp_timeout (drp_timeout)
  );

  typedef struct {
    logic [15:0] rdata;
    int          low;
    logic        tmo;
    int          id;
  } lbus_exp_t;

  typedef struct {
    logic [6:0]  daddr;
    logic        dwe;
    logic [15:0] di;
    int          lat;      // drdy delay after den; 0 = XADC never answers
    logic [15:0] do_val;
    int          id;
  } drp_exp_t;

  lbus_exp_t   lbus_q[$];
  drp_exp_t    drp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          txn_id = 0;
  bit          mon_en = 1'b0;
  logic [15:0] model_rdata = 16'h0000;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %h, expected %h", name, id, act, exp);
    end
  endtask

  // lbus monitor: one comparison set per wait_n rising edge
  initial begin
    int        low;
    logic      prev;
    lbus_exp_t e;
    low  = 0;
    prev = 1'b1;
    forever begin
      @(negedge clk_cfg);
      if (rst_cfg || !mon_en) begin
        low  = 0;
        prev = 1'b1;
      end else if (!lbus.lbus_wait_n) begin
        low++;
        prev = 1'b0;
      end else begin
        if (!prev) begin
          if (lbus_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_completion: got wait_n rise, expected none");
          end else begin
            e = lbus_q.pop_front();
            chk("lbus_rdata", e.id, 32'(lbus.lbus_rdata), 32'(e.rdata));
            chk("wait_low_cycles", e.id, low, e.low);
            chk("drp_timeout", e.id, 32'(drp_timeout), 32'(e.tmo));
          end
        end
        low  = 0;
        prev = 1'b1;
      end
    end
  end

  // DRP side: checks each den pulse and plays the XADC's drdy/do response
  initial begin
    int          cnt;
    logic [15:0] rdo;
    bit          outst;
    drp_exp_t    d;
    cnt      = 0;
    rdo      = '0;
    outst    = 1'b0;
    drp_drdy = 1'b0;
    drp_do   = '0;
    forever begin
      @(negedge clk_cfg);
      drp_drdy = 1'b0;
      drp_do   = 16'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drp_drdy = 1'b1;
          drp_do   = rdo;
          outst    = 1'b0;
        end
      end
      if (rst_cfg) outst = 1'b0;
      if (drp_den && !rst_cfg) begin
        chk("den_while_outstanding", txn_id, 32'(outst), 32'd0);
        if (drp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_den: got den=1 daddr=%h, expected no access", drp_daddr);
        end else begin
          d = drp_q.pop_front();
          chk("drp_daddr", d.id, 32'(drp_daddr), 32'(d.daddr));
          chk("drp_dwe", d.id, 32'(drp_dwe), 32'(d.dwe));
          chk("drp_di", d.id, 32'(drp_di), 32'(d.di));
          if (d.lat > 0) begin
            cnt   = d.lat;
            rdo   = d.do_val;
            outst = 1'b1;
          end
        end
      end
    end
  end

  task automatic release_strobes();
    lbus.lbus_oe_n = 1'b1;
    lbus.lbus_we_n = 1'b1;
  endtask

  // Expected behaviour: in-window cycles complete one cycle after drdy,
  // reads return drp_do, writes leave rdata alone, out-of-window reads 0.
  task automatic do_txn(input bit we, input logic [11:0] addr, input logic [15:0] wdata,
                        input int lat, input logic [15:0] do_val, input bit early, input int gap);
    bit        in_win;
    lbus_exp_t e;
    drp_exp_t  d;
    int        n;
    in_win = (addr >= 12'h800) && (addr <= 12'h87F);
    e.id   = txn_id;
    d.id   = txn_id;
    if (in_win) begin
      d.daddr  = 7'(addr - 12'h800);
      d.dwe    = we;
      d.di     = wdata;
      d.lat    = lat;
      d.do_val = do_val;
      drp_q.push_back(d);
      if (lat == 0) begin
        e.rdata = 16'hDEAD;
        e.low   = TB_TIMEOUT + 1;
        e.tmo   = 1'b1;
      end else begin
        e.rdata = we ? model_rdata : do_val;
        e.low   = lat + 1;
        e.tmo   = 1'b0;
      end
    end else begin
      e.rdata = 16'h0000;
      e.low   = 1;
      e.tmo   = 1'b0;
    end
    model_rdata = e.rdata;
    lbus_q.push_back(e);
    $display("txn %0d: %s addr=%h wdata=%h lat=%0d early=%0d exp_rdata=%h",
             txn_id, we ? "WR" : "RD", addr, wdata, lat, early, e.rdata);

    lbus.lbus_addr  = addr;
    lbus.lbus_wdata = wdata;
    if (we) begin
      lbus.lbus_we_n = 1'b0;
      lbus.lbus_oe_n = 1'($urandom_range(0, 1));
    end else begin
      lbus.lbus_oe_n = 1'b0;
    end
    @(negedge clk_cfg);
    n = 1;
    if (early) release_strobes();
    while (!lbus.lbus_wait_n && n < WAIT_BOUND) begin
      @(negedge clk_cfg);
      n++;
    end
    if (n >= WAIT_BOUND) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_n_stuck (txn %0d): got wait_n=0 for %0d cycles, expected release", txn_id, n);
    end
    release_strobes();
    repeat (gap) @(negedge clk_cfg);
    txn_id++;
  endtask

  initial begin
    drp_exp_t    d;
    logic [11:0] a;
    int          lat;
    bit          in_w;

    lbus.lbus_addr  = '0;
    lbus.lbus_wdata = '0;
    release_strobes();
    repeat (2) @(negedge clk_cfg);
    chk("reset_wait_n", -1, 32'(lbus.lbus_wait_n), 32'd1);
    chk("reset_rdata", -1, 32'(lbus.lbus_rdata), 32'd0);
    chk("reset_den", -1, 32'(drp_den), 32'd0);
    chk("reset_dwe", -1, 32'(drp_dwe), 32'd0);
    chk("reset_daddr", -1, 32'(drp_daddr), 32'd0);
    chk("reset_di", -1, 32'(drp_di), 32'd0);
    chk("reset_timeout", -1, 32'(drp_timeout), 32'd0);
    rst_cfg = 1'b0;
    repeat (2) @(negedge clk_cfg);
    mon_en = 1'b1;

    do_txn(1'b0, 12'h800, 16'h0000, 3, 16'h9A30, 1'b0, 2);
    do_txn(1'b1, 12'h841, 16'h1234, 2, 16'h5555, 1'b0, 2);
    do_txn(1'b0, 12'h123, 16'h0000, 1, 16'h0000, 1'b0, 2);
    do_txn(1'b0, 12'h800, 16'h0000, 2, 16'h1111, 1'b0, 1);
    do_txn(1'b0, 12'h801, 16'h0000, 4, 16'h2222, 1'b0, 1);
    do_txn(1'b0, 12'h87F, 16'h0000, 1, 16'h3C3C, 1'b1, 1);
`ifdef DRP_TIMEOUT_EN
    do_txn(1'b0, 12'h801, 16'h0000, 0, 16'h0000, 1'b0, 2);
`endif

    // Reset while the DRP access is outstanding; its late drdy must be ignored
    mon_en   = 1'b0;
    d.daddr  = 7'h02;
    d.dwe    = 1'b0;
    d.di     = 16'hA5A5;
    d.lat    = 8;
    d.do_val = 16'h7E57;
    d.id     = txn_id;
    drp_q.push_back(d);
    $display("txn %0d: RD addr=802 reset during WAIT_RDY", txn_id);
    lbus.lbus_addr  = 12'h802;
    lbus.lbus_wdata = 16'hA5A5;
    lbus.lbus_oe_n  = 1'b0;
    repeat (3) @(negedge clk_cfg);
    chk("pre_reset_wait_n", txn_id, 32'(lbus.lbus_wait_n), 32'd0);
    rst_cfg = 1'b1;
    #1;
    chk("mid_reset_wait_n", txn_id, 32'(lbus.lbus_wait_n), 32'd1);
    chk("mid_reset_den", txn_id, 32'(drp_den), 32'd0);
    chk("mid_reset_rdata", txn_id, 32'(lbus.lbus_rdata), 32'd0);
    chk("mid_reset_timeout", txn_id, 32'(drp_timeout), 32'd0);
    release_strobes();
    @(negedge clk_cfg);
    rst_cfg = 1'b0;
    repeat (10) begin
      @(negedge clk_cfg);
      chk("post_reset_wait_n", txn_id, 32'(lbus.lbus_wait_n), 32'd1);
      chk("post_reset_rdata", txn_id, 32'(lbus.lbus_rdata), 32'd0);
    end
    model_rdata = 16'h0000;
    mon_en      = 1'b1;
    txn_id++;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        a = 12'h800 + 12'($urandom_range(0, 127));
      end else begin
        a = 12'($urandom);
        in_w = (a >= 12'h800) && (a <= 12'h87F);
        if (in_w) a = a ^ 12'h400;
      end
      lat = $urandom_range(1, 6);
      do_txn(1'($urandom_range(0, 1)), a, 16'($urandom), lat, 16'($urandom),
             ($urandom_range(0, 3) == 0), $urandom_range(1, 3));
    end

    repeat (5) @(negedge clk_cfg);
    chk("lbus_queue_drained", -1, 32'(lbus_q.size()), 32'd0);
    chk("drp_queue_drained", -1, 32'(drp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
